// File: rtl/ws2811_pkg.sv
// Shared WS2811 protocol definitions: receiver state encoding, default line
// timing at 50 MHz (common with the PWM encoder) and pixel geometry.
package ws2811_pkg;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    HIGH   = 2'd2,
    LOW    = 2'd3
  } rx_state_t;

  localparam int CLK_HZ     = 50_000_000;
  localparam int T0H        = 17;
  localparam int T0L        = 40;
  localparam int T1H        = 35;
  localparam int T1L        = 28;
  localparam int TRESET     = 2500;
  localparam int PIXEL_BITS = 24;

  // Nominal high time, in clk cycles, of an encoded bit.
  function automatic int high_cycles(input logic b);
    return b ? T1H : T0H;
  endfunction

  // Nominal low time, in clk cycles, following an encoded bit.
  function automatic int low_cycles(input logic b);
    return b ? T1L : T0L;
  endfunction

endpackage

// File: rtl/ws2811_sync.sv
// Two-flop synchronizer for the asynchronous WS2811 line, plus registered
// single-cycle rise/fall pulses aligned with the first cycle of the new level
// on s_din.
module ws2811_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic s_din,
  output logic rise,
  output logic fall
);

  logic meta;

  // Synchronize din and flag level changes of the synchronized line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      s_din <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= din;
      s_din <= meta;
      rise  <= meta & ~s_din;
      fall  <= ~meta & s_din;
    end
  end

endmodule

// File: rtl/ws2811_rx_decoder.sv
// WS2811 NRZ receiver: measures each high pulse, decodes 24-bit pixels MSB
// first, detects the frame-end reset gap and, in forwarding mode, captures
// only the first pixel and regenerates the rest of the frame on dout.
//
// state  | meaning
// RESYNC | waiting for a full reset gap before trusting the line
// IDLE   | line low between frames, waiting for the first bit
// HIGH   | measuring a high pulse
// LOW    | measuring the low time after a bit
module ws2811_rx_decoder
  import ws2811_pkg::*;
#(
  parameter int T_THRESH   = 25,
  parameter int T_MIN_HIGH = 5,
  parameter int T_MAX_HIGH = 60,
  parameter int T_RESET    = TRESET,
  parameter int FORWARD    = 0,
  parameter int PIX_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  output logic [PIXEL_BITS-1:0] pixel_data,
  output logic                  pixel_valid,
  output logic [PIX_W-1:0]      pixel_index,
  output logic                  frame_end,
  output logic                  err,
  output logic                  dout
);

  localparam int HW = $clog2(T_MAX_HIGH + 2);
  localparam int LW = $clog2(T_RESET + 1);
  localparam int BW = $clog2(PIXEL_BITS + 1);

  localparam logic [HW-1:0] HC_ONE    = HW'(1);
  localparam logic [HW-1:0] HC_MIN    = HW'(T_MIN_HIGH);
  localparam logic [HW-1:0] HC_THRESH = HW'(T_THRESH);
  localparam logic [HW-1:0] HC_MAX    = HW'(T_MAX_HIGH);
  localparam logic [HW-1:0] HC_SAT    = HW'(T_MAX_HIGH + 1);
  localparam logic [LW-1:0] LC_ONE    = LW'(1);
  localparam logic [LW-1:0] LC_RESET  = LW'(T_RESET);
  localparam logic [BW-1:0] BC_ONE    = BW'(1);
  localparam logic [BW-1:0] BC_LAST   = BW'(PIXEL_BITS - 1);
  localparam logic [PIX_W-1:0] IDX_ONE = PIX_W'(1);

  rx_state_t             state;
  logic                  s_din;
  logic                  rise;
  logic                  fall;
  logic [HW-1:0]         hcnt;
  logic [HW-1:0]         hcnt_inc;
  logic [LW-1:0]         lcnt;
  logic [LW-1:0]         lcnt_inc;
  logic [BW-1:0]         bitcnt;
  logic [PIXEL_BITS-1:0] shreg;
  logic [PIXEL_BITS-1:0] word_next;
  logic                  bit_val;
  logic [PIX_W-1:0]      idx_cnt;
  logic [PIX_W-1:0]      idx_inc;
  logic                  fwd;

  ws2811_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .s_din (s_din),
    .rise  (rise),
    .fall  (fall)
  );

  // Saturating counter increments and the word as it looks with the bit
  // currently being measured shifted in.
  always_comb begin
    hcnt_inc  = (hcnt == HC_SAT) ? hcnt : hcnt + HC_ONE;
    lcnt_inc  = (lcnt == LC_RESET) ? lcnt : lcnt + LC_ONE;
    idx_inc   = (idx_cnt == '1) ? idx_cnt : idx_cnt + IDX_ONE;
    bit_val   = (hcnt >= HC_THRESH);
    word_next = {shreg[PIXEL_BITS-2:0], bit_val};
  end

  // Receive state machine with registered strobes and pixel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RESYNC;
      hcnt        <= '0;
      lcnt        <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      idx_cnt     <= '0;
      fwd         <= 1'b0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      frame_end   <= 1'b0;
      err         <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_end   <= 1'b0;
      err         <= 1'b0;

      unique case (state)
        RESYNC: begin
          if (s_din) begin
            lcnt <= '0;
          end else begin
            lcnt <= lcnt_inc;
            if (lcnt_inc == LC_RESET) begin
              state <= IDLE;
            end
          end
        end

        IDLE: begin
          lcnt <= '0;
          if (rise) begin
            state       <= HIGH;
            hcnt        <= HC_ONE;
            bitcnt      <= '0;
            idx_cnt     <= '0;
            pixel_index <= '0;
            fwd         <= 1'b0;
          end
        end

        HIGH: begin
          if (fall) begin
            hcnt <= '0;
            lcnt <= LC_ONE;
            if (fwd) begin
              state <= LOW;
            end else if (hcnt < HC_MIN) begin
              err   <= 1'b1;
              state <= RESYNC;
              lcnt  <= '0;
            end else begin
              state <= LOW;
              shreg <= word_next;
              if (bitcnt == BC_LAST) begin
                bitcnt      <= '0;
                pixel_data  <= word_next;
                pixel_valid <= 1'b1;
                pixel_index <= idx_cnt;
                idx_cnt     <= idx_inc;
                fwd         <= (FORWARD != 0);
              end else begin
                bitcnt <= bitcnt + BC_ONE;
              end
            end
          end else if (!fwd && hcnt >= HC_MAX) begin
            // This cycle is high sample T_MAX_HIGH+1: the pulse is too long.
            err   <= 1'b1;
            state <= RESYNC;
            hcnt  <= '0;
            lcnt  <= '0;
          end else begin
            hcnt <= hcnt_inc;
          end
        end

        LOW: begin
          if (rise) begin
            state <= HIGH;
            hcnt  <= HC_ONE;
          end else begin
            lcnt <= lcnt_inc;
            if (lcnt_inc == LC_RESET) begin
              frame_end <= 1'b1;
              fwd       <= 1'b0;
              if (bitcnt != '0) begin
                // Partial pixel is dropped. The gap just seen already counts
                // as the resync gap, so RESYNC exits on the next low cycle.
                err    <= 1'b1;
                bitcnt <= '0;
                state  <= RESYNC;
              end else begin
                state <= IDLE;
              end
            end
          end
        end

        default: begin
          state <= RESYNC;
        end
      endcase
    end
  end

  // Regenerated line: one register behind s_din while forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= 1'b0;
    end else begin
      dout <= (FORWARD != 0) && fwd && s_din;
    end
  end

endmodule
